vga_console_term_ctrl: RTL and testbench

//  Terminal sequencer for the VGA text console buffer (NUM_ROWS x NUM_COLS cells, {color[2:0],char[6:0]}).

---
 rtl/vga_console_term_ctrl.sv | 177 +++++++++++++++++
 tb/tb_vga_console_term_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_console_term_ctrl.sv
// Terminal sequencer for the VGA text console: cursor tracking, control decode, scroll/clear sequencing.
// Optional VBLANK_SYNC_EN: scroll and clear sequences wait in WAIT_VB until vblank is high.
module vga_console_term_ctrl #(
    parameter int unsigned NUM_ROWS      = 3,
    parameter int unsigned NUM_COLS      = 10,
    parameter int unsigned ADDR_W        = 6,
    parameter logic [2:0]  DEFAULT_COLOR = 3'b010
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        char_valid,
    input  logic [7:0]                  char_data,
    output logic                        char_ready,
    input  logic                        color_we,
    input  logic [2:0]                  color_in,
    input  logic                        vblank,
    output logic                        buf_we,
    output logic [ADDR_W-1:0]           buf_waddr,
    output logic [9:0]                  buf_wdata,
    output logic [ADDR_W-1:0]           buf_raddr,
    input  logic [9:0]                  buf_rdata,
    output logic [$clog2(NUM_ROWS)-1:0] cursor_row,
    output logic [$clog2(NUM_COLS)-1:0] cursor_col,
    output logic                        busy
);

    localparam int unsigned NUM_CHARS = NUM_ROWS * NUM_COLS;
    localparam int unsigned ROW_W     = $clog2(NUM_ROWS);
    localparam int unsigned COL_W     = $clog2(NUM_COLS);
    localparam int unsigned K_W       = $clog2(NUM_CHARS);
    localparam int unsigned COPY_LAST = NUM_CHARS - NUM_COLS - 1;
    localparam int unsigned FILL_BASE = (NUM_ROWS - 1) * NUM_COLS;
    localparam logic [6:0]  SPACE     = 7'h20;

    typedef enum logic [2:0] {S_IDLE, S_COPY, S_FILL, S_CLEAR, S_WAIT_VB} state_t;

`ifdef VBLANK_SYNC_EN
    localparam state_t ENTRY_COPY  = S_WAIT_VB;
    localparam state_t ENTRY_CLEAR = S_WAIT_VB;
    logic r_vb_copy;
`else
    localparam state_t ENTRY_COPY  = S_COPY;
    localparam state_t ENTRY_CLEAR = S_CLEAR;
    logic w_unused_vblank;
    assign w_unused_vblank = vblank;
`endif

    state_t             r_state;
    logic [K_W-1:0]     r_k;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic [2:0]         r_color;
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [9:0]         r_wdata;

    logic               w_print;
    logic               w_lf;
    logic               w_last_row;
    logic               w_last_col;
    logic [ADDR_W-1:0]  w_cur_addr;

    assign w_print    = (char_data >= 8'h20) && (char_data <= 8'h7E);
    assign w_last_col = (r_col == COL_W'(NUM_COLS - 1));
    assign w_last_row = (r_row == ROW_W'(NUM_ROWS - 1));
    // A printable byte in the last column wraps exactly like an explicit line feed.
    assign w_lf       = (w_print && w_last_col) || (char_data == 8'h0A);
    assign w_cur_addr = ADDR_W'(r_row) * ADDR_W'(NUM_COLS) + ADDR_W'(r_col);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ENTRY_CLEAR;
            r_k     <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_color <= DEFAULT_COLOR;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
`ifdef VBLANK_SYNC_EN
            r_vb_copy <= 1'b0;
`endif
        end else begin
            r_we <= 1'b0;
            if (color_we) r_color <= color_in;
            case (r_state)
                S_IDLE: begin
                    if (char_valid) begin
                        if (w_print) begin
                            r_we    <= 1'b1;
                            r_waddr <= w_cur_addr;
                            r_wdata <= {r_color, char_data[6:0]};
                            r_col   <= w_last_col ? '0 : r_col + 1'b1;
                        end else if (char_data == 8'h0A || char_data == 8'h0D) begin
                            r_col <= '0;
                        end else if (char_data == 8'h08) begin
                            if (r_col != '0) r_col <= r_col - 1'b1;
                        end else if (char_data == 8'h0C) begin
                            r_row   <= '0;
                            r_col   <= '0;
                            r_k     <= '0;
                            r_state <= ENTRY_CLEAR;
`ifdef VBLANK_SYNC_EN
                            r_vb_copy <= 1'b0;
`endif
                        end
                        if (w_lf) begin
                            if (!w_last_row) begin
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_k     <= '0;
                                r_state <= ENTRY_COPY;
`ifdef VBLANK_SYNC_EN
                                r_vb_copy <= 1'b1;
`endif
                            end
                        end
                    end
                end
                S_COPY: begin
                    r_we    <= 1'b1;
                    r_waddr <= ADDR_W'(r_k);
                    r_wdata <= buf_rdata;
                    if (r_k == K_W'(COPY_LAST)) begin
                        r_k     <= '0;
                        r_state <= S_FILL;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_FILL: begin
                    r_we    <= 1'b1;
                    r_waddr <= ADDR_W'(FILL_BASE) + ADDR_W'(r_k);
                    r_wdata <= {r_color, SPACE};
                    if (r_k == K_W'(NUM_COLS - 1)) begin
                        r_k     <= '0;
                        r_row   <= ROW_W'(NUM_ROWS - 1);
                        r_col   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_we    <= 1'b1;
                    r_waddr <= ADDR_W'(r_k);
                    r_wdata <= {r_color, SPACE};
                    if (r_k == K_W'(NUM_CHARS - 1)) begin
                        r_k     <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
`ifdef VBLANK_SYNC_EN
                S_WAIT_VB: begin
                    if (vblank) begin
                        r_k     <= '0;
                        r_state <= r_vb_copy ? S_COPY : S_CLEAR;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign char_ready = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign buf_raddr  = ADDR_W'(r_k) + ADDR_W'(NUM_COLS);
    assign buf_we     = r_we;
    assign buf_waddr  = r_waddr;
    assign buf_wdata  = r_wdata;
    assign cursor_row = r_row;
    assign cursor_col = r_col;

endmodule

// File: tb/tb_vga_console_term_ctrl.sv
// Bench for vga_console_term_ctrl: directed sequences plus random byte streams against a screen-level model.
module tb_vga_console_term_ctrl;

    localparam int NR = 3;
    localparam int NC = 10;
    localparam int NCH = NR * NC;
`ifdef VBLANK_SYNC_EN
    localparam int SEQ_CYC = NCH + 1;
`else
    localparam int SEQ_CYC = NCH;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic       color_we;
    logic [2:0] color_in;
    logic       vblank;
    logic       buf_we;
    logic [5:0] buf_waddr;
    logic [9:0] buf_wdata;
    logic [5:0] buf_raddr;
    logic [9:0] buf_rdata;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;

    vga_console_term_ctrl dut (
        .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .color_we(color_we), .color_in(color_in), .vblank(vblank),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .buf_raddr(buf_raddr),
        .buf_rdata(buf_rdata), .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
    );

    always #5 clk = ~clk;

    // Text buffer stand-in plus a log of every write seen on the port.
    typedef struct { int c; logic [5:0] a; logic [9:0] d; } wr_t;
    logic [9:0] mem [0:63];
    wr_t        wq [$];
    int         cyc = 0;
    assign buf_rdata = mem[buf_raddr];
    always @(posedge clk) begin
        if (buf_we) begin
            mem[buf_waddr] <= buf_wdata;
            wq.push_back('{c: cyc, a: buf_waddr, d: buf_wdata});
        end
        cyc <= cyc + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        char_valid = 1'b1;
        char_data  = b;
        tick();
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!char_ready && n < 400) begin
            tick();
            n++;
        end
        chk({tag, " idle"}, 32'(char_ready), 1);
    endtask

    task automatic chk_cur(input string tag, input int r, input int c);
        chk({tag, " row"}, 32'(cursor_row), r);
        chk({tag, " col"}, 32'(cursor_col), c);
    endtask

    logic [5:0] ea [$];
    logic [9:0] ed [$];

    // Compares logged writes from index base against ea/ed, requiring back-to-back cycles.
    task automatic chk_writes(input string tag, input int base);
        int n = wq.size() - base;
        chk({tag, " count"}, n, ea.size());
        for (int i = 0; i < ea.size() && i < n; i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), 32'(wq[base + i].a), 32'(ea[i]));
            chk($sformatf("%s data[%0d]", tag, i), 32'(wq[base + i].d), 32'(ed[i]));
            chk($sformatf("%s cyc[%0d]", tag, i), wq[base + i].c - wq[base].c, i);
        end
        ea.delete();
        ed.delete();
    endtask

    // Screen-level reference model.
    logic [9:0] scr [NCH];
    int         mrow, mcol, mbusy;
    logic [2:0] mcolor;

    task automatic model_fill(input int lo);
        for (int i = lo; i < NCH; i++) scr[i] = {mcolor, 7'h20};
    endtask

    task automatic model_apply(input logic [7:0] b, input logic cw, input logic [2:0] ci);
        bit lf = 0;
        bit clr = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mrow * NC + mcol] = {mcolor, b[6:0]};
            if (mcol < NC - 1) mcol++;
            else begin mcol = 0; lf = 1; end
        end else if (b == 8'h0A) begin
            mcol = 0; lf = 1;
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (b == 8'h0C) begin
            mrow = 0; mcol = 0; clr = 1;
        end
        if (cw) mcolor = ci;
        if (lf) begin
            if (mrow < NR - 1) mrow++;
            else begin
                for (int i = 0; i < NCH - NC; i++) scr[i] = scr[i + NC];
                model_fill(NCH - NC);
                mbusy = SEQ_CYC;
            end
        end
        if (clr) begin
            model_fill(0);
            mbusy = SEQ_CYC;
        end
    endtask

    function automatic logic [7:0] pick_byte();
        int r = $urandom_range(0, 19);
        if (r == 0) return 8'h0A;
        if (r == 1) return 8'h0D;
        if (r == 2) return 8'h08;
        if (r == 3) return ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h0A;
        if (r == 4) return 8'h80 | 8'($urandom_range(0, 127));
        if (r == 5) return 8'($urandom_range(0, 7)) | 8'h10;
        return 8'($urandom_range(32, 126));
    endfunction

    logic [9:0] img [NCH];

    initial begin
        int base;
        int n;
        rst_n = 1'b0; char_valid = 1'b0; char_data = 8'h00;
        color_we = 1'b0; color_in = 3'b000; vblank = 1'b1;
        repeat (3) tick();
        chk("rst buf_we", 32'(buf_we), 0);
        chk("rst waddr", 32'(buf_waddr), 0);
        chk("rst wdata", 32'(buf_wdata), 0);
        chk("rst ready", 32'(char_ready), 0);
        chk("rst busy", 32'(busy), 1);
        chk_cur("rst", 0, 0);

        // Reset clear: 30 writes of a default-colored space.
        base = wq.size();
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) begin ea.push_back(6'(i)); ed.push_back(10'h120); end
        wait_idle("rstclr");
        tick();
        chk_writes("rstclr", base);
        chk_cur("rstclr", 0, 0);

        base = wq.size();
        put("A"); put("B");
        tick();
        ea = '{6'd0, 6'd1}; ed = '{10'h141, 10'h142};
        chk_writes("AB", base);
        chk_cur("AB", 0, 2);

        base = wq.size();
        put(8'h0C);
        for (int i = 0; i < NCH; i++) begin ea.push_back(6'(i)); ed.push_back(10'h120); img[i] = 10'h120; end
        wait_idle("ff1");
        tick();
        chk_writes("ff1", base);
        chk_cur("ff1", 0, 0);

        // Row 0 wraps to row 1 on the 10th character.
        base = wq.size();
        for (int i = 0; i < NC; i++) begin
            put(8'h30 + 8'(i));
            img[i] = {3'b010, 7'(8'h30 + 8'(i))};
            ea.push_back(6'(i)); ed.push_back(img[i]);
        end
        tick();
        chk_writes("row0", base);
        chk_cur("row0", 1, 0);

        base = wq.size();
        put(8'h08);
        tick();
        chk("bs nowrite", wq.size() - base, 0);
        chk_cur("bs", 1, 0);

        base = wq.size();
        put(8'h85); put(8'h01); put(8'h7F);
        tick();
        chk("ignored nowrite", wq.size() - base, 0);
        chk_cur("ignored", 1, 0);

        base = wq.size();
        for (int i = 0; i < NC; i++) begin
            put(8'h61 + 8'(i));
            img[NC + i] = {3'b010, 7'(8'h61 + 8'(i))};
            ea.push_back(6'(NC + i)); ed.push_back(img[NC + i]);
        end
        for (int i = 0; i < NC - 1; i++) begin
            put(8'h4B + 8'(i));
            img[2 * NC + i] = {3'b010, 7'(8'h4B + 8'(i))};
            ea.push_back(6'(2 * NC + i)); ed.push_back(img[2 * NC + i]);
        end
        tick();
        chk_writes("rows12", base);
        chk_cur("rows12", 2, 9);

        // Line feed on the last row scrolls.
        base = wq.size();
        put(8'h0A);
        n = 0;
        while (busy && n < 200) begin n++; tick(); end
        chk("scroll busy cycles", n, SEQ_CYC);
        tick();
        for (int k = 0; k < NCH - NC; k++) begin ea.push_back(6'(k)); ed.push_back(img[k + NC]); end
        for (int k = NCH - NC; k < NCH; k++) begin ea.push_back(6'(k)); ed.push_back(10'h120); end
        chk_writes("scroll", base);
        chk_cur("scroll", 2, 0);

        put(8'h0C);
        wait_idle("ff2");
        tick();
        put(8'h0A); put("x"); put("y"); put("z");
        color_we = 1'b1; color_in = 3'b100;
        tick();
        color_we = 1'b0;
        base = wq.size();
        put("Z");
        tick();
        ea = '{6'd13}; ed = '{10'h25A};
        chk_writes("colorZ", base);
        chk_cur("colorZ", 1, 4);

        base = wq.size();
        put(8'h0C);
        for (int i = 0; i < NCH; i++) begin ea.push_back(6'(i)); ed.push_back(10'h220); end
        wait_idle("ff3");
        tick();
        chk_writes("ff3", base);
        chk_cur("ff3", 0, 0);

        // Random streams against the screen model.
        for (int i = 0; i < NCH; i++) scr[i] = 10'h220;
        mrow = 0; mcol = 0; mbusy = 0; mcolor = 3'b100;
        for (int r = 0; r < 4; r++) begin
            for (int t = 0; t < 300; t++) begin
                logic       v, cw, exp_rdy;
                logic [7:0] b;
                logic [2:0] ci;
                exp_rdy = (mbusy == 0);
                chk("rnd ready", 32'(char_ready), 32'(exp_rdy));
                chk_cur("rnd", mrow, mcol);
                if (mbusy > 0) mbusy--;
                v  = ($urandom_range(0, 3) != 0);
                b  = pick_byte();
                cw = exp_rdy && ($urandom_range(0, 15) == 0);
                ci = 3'($urandom_range(0, 7));
                char_valid = v; char_data = b; color_we = cw; color_in = ci;
                @(posedge clk);
                if (v && exp_rdy) model_apply(b, cw, ci);
                else if (cw) mcolor = ci;
                #1;
            end
            char_valid = 1'b0; color_we = 1'b0;
            wait_idle("rnd drain");
            tick(); tick();
            mbusy = 0;
            chk_cur("rnd drain", mrow, mcol);
            for (int i = 0; i < NCH; i++) chk($sformatf("rnd%0d cell%0d", r, i), 32'(mem[i]), 32'(scr[i]));
        end

`ifdef VBLANK_SYNC_EN
        vblank = 1'b0;
        base = wq.size();
        put(8'h0C);
        repeat (4) tick();
        chk("vb hold busy", 32'(busy), 1);
        chk("vb hold ready", 32'(char_ready), 0);
        chk("vb hold nowrite", wq.size() - base, 0);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        for (int i = 0; i < NCH; i++) begin ea.push_back(6'(i)); ed.push_back({mcolor, 7'h20}); end
        wait_idle("vb");
        tick();
        chk_writes("vb", base);
        chk_cur("vb", 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
